// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and the width-generic immediate extension function
// used by the immediate-extension pipeline stage.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SIGN = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_LUI  = 2'b10;
  localparam logic [1:0] MODE_SHL2 = 2'b11;

  // Working width of ext_imm; callers need IN_W+2 <= OUT_W < EXT_MAX_W.
  localparam int EXT_MAX_W = 128;

  // Extends the low in_w bits of imm to out_w bits; bits at or above out_w
  // are returned as zero so the caller can slice the low out_w bits.
  function automatic logic [EXT_MAX_W-1:0] ext_imm(
    input logic [EXT_MAX_W-1:0] imm,
    input logic [1:0]           mode,
    input int                   in_w,
    input int                   out_w
  );
    logic [EXT_MAX_W-1:0] ones;
    logic [EXT_MAX_W-1:0] one;
    logic [EXT_MAX_W-1:0] in_mask;
    logic [EXT_MAX_W-1:0] out_mask;
    logic [EXT_MAX_W-1:0] field;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    logic                 sign;
    ones     = {EXT_MAX_W{1'b1}};
    one      = {{(EXT_MAX_W-1){1'b0}}, 1'b1};
    in_mask  = ~(ones << in_w);
    out_mask = ~(ones << out_w);
    field    = imm & in_mask;
    sign     = |(imm & (one << (in_w - 1)));
    sext     = sign ? (field | ~in_mask) : field;
    case (mode)
      MODE_SIGN: res = sext;
      MODE_ZERO: res = field;
      MODE_LUI:  res = field << (out_w - in_w);
      default:   res = sext << 2;
    endcase
    return res & out_mask;
  endfunction

endpackage

// File: rtl/skid_reg2.sv
// Generic two-entry valid/ready skid buffer: a main output register plus one
// skid register that catches the entry accepted while the output is stalled.
module skid_reg2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic main_free;

  assign in_ready  = ~skid_valid_q & ~reset;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_free) begin
      if (skid_valid_q) begin
        // The older skid entry always drains ahead of anything newer.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = in_data;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = in_data;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage: extends the immediate combinationally
// at the input and stores {extended value, tag} in a two-entry skid buffer.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int ENTRY_W = OUT_W + TAG_W;

  logic [EXT_MAX_W-1:0] ext_full;
  logic                 ext_unused;
  logic [ENTRY_W-1:0]   entry_in;
  logic [ENTRY_W-1:0]   entry_out;

  // Mode is consumed here; only the extended value travels down the pipe.
  assign ext_full   = ext_imm(EXT_MAX_W'(in_imm), in_mode, IN_W, OUT_W);
  assign ext_unused = ^ext_full[EXT_MAX_W-1:OUT_W];
  assign entry_in   = {ext_full[OUT_W-1:0], in_tag};

  skid_reg2 #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (entry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (entry_out)
  );

  assign out_data = entry_out[TAG_W +: OUT_W];
  assign out_tag  = entry_out[TAG_W-1:0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: a driver pushes expected results as
// entries are accepted, a monitor pops and compares on every output transfer.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: the value of the immediate as an integer, then scaled/placed.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    int u;
    s = int'($signed(imm));
    u = int'(imm);
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, output int waits);
    exp_t e;
    waits    = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = ref_ext(imm, mode);
        e.tag  = tag;
        sb.push_back(e);
        $display("send  cyc=%0d imm=%h mode=%0d tag=%0d exp=%h", cyc, imm, mode, tag, e.data);
        @(posedge clk);
        #1;
        return;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 32'(waits), 32'd0);
  endtask

  // Monitor: compare on every transfer, and require stability while stalled.
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_tag;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, held_data);
        chk("stall_tag", 32'(out_tag), 32'(held_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h/%0d required no output", out_data, out_tag);
        end else begin
          e = sb.pop_front();
          $display("recv  cyc=%0d data=%h tag=%0d exp=%h/%0d", cyc, out_data, out_tag, e.data, e.tag);
          chk("out_data", out_data, e.data);
          chk("out_tag", 32'(out_tag), 32'(e.tag));
          pop_cyc.push_back(cyc);
        end
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_tag  = out_tag;
    end
  end

  logic [15:0] dir_imm  [8] = '{16'h1000, 16'h9000, 16'h9000, 16'hFFFF,
                                16'h1234, 16'h7FFF, 16'hFFFF, 16'h8000};
  logic [1:0]  dir_mode [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [31:0] dir_exp  [8] = '{32'h00001000, 32'hFFFF9000, 32'h00009000, 32'hFFFFFFFF,
                                32'h12340000, 32'h0001FFFC, 32'hFFFFFFFC, 32'hFFFE0000};

  bit rand_done;

  initial begin
    int w;
    int np;
    logic [31:0] d0;
    logic [4:0]  t0;
    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed modes, one-cycle latency, unstalled.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ref_table", ref_ext(dir_imm[i], dir_mode[i]), dir_exp[i]);
      send(dir_imm[i], dir_mode[i], 5'(i + 3), w);
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_data", out_data, dir_exp[i]);
      @(posedge clk); #1;
    end

    // Streaming: 8 back-to-back entries, no bubbles either side.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 2'($urandom), 5'(i), w);
      chk("stream_in_ready", 32'(w), 32'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stream_pops", 32'(pop_cyc.size()), 32'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("stream_no_bubble", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

    // Backpressure: A, B accepted; C held until a pop frees the skid.
    out_ready = 1'b0;
    send(16'hAAAA, 2'd1, 5'd10, w);
    send(16'hBBBB, 2'd1, 5'd11, w);
    in_imm = 16'hCCCC; in_mode = 2'd1; in_tag = 5'd12;
    @(negedge clk);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'hCCCC, 2'd1, 5'd12, w);
    chk("bp_ready_return", 32'(w), 32'd1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Stall stability with no extra pops.
    out_ready = 1'b0;
    send(16'h5A5A, 2'd0, 5'd21, w);
    in_valid = 1'b0;
    @(negedge clk);
    d0 = out_data; t0 = out_tag; np = pop_cyc.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stable_data", out_data, d0);
      chk("stable_tag", 32'(out_tag), 32'(t0));
    end
    chk("stable_no_pop", 32'(pop_cyc.size()), 32'(np));
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with both registers full; the reset-cycle entry is not taken.
    out_ready = 1'b0;
    send(16'h1111, 2'd0, 5'd1, w);
    send(16'h2222, 2'd0, 5'd2, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1; in_imm = 16'h3333; in_tag = 5'd3;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'h4444, 2'd2, 5'd4, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_reset_first", out_data, 32'h44440000);
    @(posedge clk); #1;

    // Randomized traffic with random downstream stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(16'($urandom), 2'($urandom), 5'($urandom), w);
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
